// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed seven-segment scanner with anti-ghosting blank gap
//
// Ports:
//   clk_in      system clock, the only clock in the block
//   reset       asynchronous active-low reset, released synchronously upstream
//   tick_in     slow scan-rate square wave; sampled on clk_in, never used as a clock
//   value_in    packed hex digits, digit i = value_in[4i+3:4i]
//   dp_in       per-digit decimal point request, active-high
//   digit_en    per-digit enable; a disabled digit keeps its slot with the anode off
//   an_n        anode drives, active-low, at most one bit low
//   seg_n       segments {g,f,e,d,c,b,a}, active-low
//   dp_n        decimal point, active-low
//   digit_sel   index of the digit whose slot is current
//   frame_done  one-cycle pulse as digit 0's slot begins
module seg7_scan_driver #(
    parameter int N_DIGITS     = 8,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                        clk_in,
    input  logic                        reset,
    input  logic                        tick_in,
    input  logic [4*N_DIGITS-1:0]       value_in,
    input  logic [N_DIGITS-1:0]         dp_in,
    input  logic [N_DIGITS-1:0]         digit_en,
    output logic [N_DIGITS-1:0]         an_n,
    output logic [6:0]                  seg_n,
    output logic                        dp_n,
    output logic [$clog2(N_DIGITS)-1:0] digit_sel,
    output logic                        frame_done
);

    localparam int SEL_W = $clog2(N_DIGITS);
    localparam int CNT_W = $clog2(BLANK_CYCLES + 1);
    localparam logic [SEL_W-1:0] LAST_SEL     = SEL_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0] BLANK_RELOAD = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    if (N_DIGITS < 2 || N_DIGITS > 16) begin : g_bad_digits
        $error("seg7_scan_driver: N_DIGITS must be in 2..16");
    end
    if (BLANK_CYCLES < 1) begin : g_bad_blank
        $error("seg7_scan_driver: BLANK_CYCLES must be >= 1");
    end

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  blank_cnt;
    logic              s1, s2, s3;
    logic              tick_rise;
    logic [SEL_W-1:0]  next_sel;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Only the selected anode may go low, and only if that digit is enabled.
    function automatic logic [N_DIGITS-1:0] anode_pattern(input logic [SEL_W-1:0] sel,
                                                          input logic [N_DIGITS-1:0] en);
        return ~(en & (N_DIGITS'(1) << sel));
    endfunction

    // s3 is a history flop behind the two-flop synchronizer.
    assign tick_rise = s2 & ~s3;
    assign next_sel  = (digit_sel == LAST_SEL) ? '0 : digit_sel + 1'b1;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            state      <= ST_BLANK;
            blank_cnt  <= BLANK_RELOAD;
            digit_sel  <= LAST_SEL;
            an_n       <= '1;
            seg_n      <= 7'h7F;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            s1         <= tick_in;
            s2         <= s1;
            s3         <= s2;
            frame_done <= 1'b0;
            case (state)
                ST_BLANK: begin
                    // tick_rise is deliberately ignored here; no advance is queued.
                    an_n  <= '1;
                    seg_n <= 7'h7F;
                    dp_n  <= 1'b1;
                    if (blank_cnt == CNT_ONE) begin
                        state      <= ST_SHOW;
                        blank_cnt  <= '0;
                        digit_sel  <= next_sel;
                        an_n       <= anode_pattern(next_sel, digit_en);
                        // seg_n/dp_n hold this snapshot for the whole slot.
                        seg_n      <= hex_decode(value_in[{next_sel, 2'b00} +: 4]);
                        dp_n       <= ~dp_in[next_sel];
                        frame_done <= (next_sel == '0);
                    end else begin
                        blank_cnt <= blank_cnt - 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (tick_rise) begin
                        state     <= ST_BLANK;
                        blank_cnt <= BLANK_RELOAD;
                        an_n      <= '1;
                        seg_n     <= 7'h7F;
                        dp_n      <= 1'b1;
                    end else begin
                        an_n <= anode_pattern(digit_sel, digit_en);
                    end
                end
                default: state <= ST_BLANK;
            endcase
        end
    end

endmodule
